// File: rtl/mem_access_ctrl.sv
// Sequences one word-level load/store into 1, 2 or 4 big-endian byte accesses
// on a byte-wide synchronous RAM, with alignment checking and load extension.
module mem_access_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sext,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_RD_LAST,
    S_DONE,
    S_ERR
  } state_t;

  state_t              r_state;
  logic [1:0]          r_size;
  logic                r_sext;
  logic [1:0]          r_cnt;
  logic                r_busy;
  logic                r_done;
  logic                r_err;
  logic                r_mem_we;
  logic                r_mem_re;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [7:0]          r_mem_wdata;
  logic [31:0]         r_rdata;
  logic [31:0]         r_wsh;
  logic [23:0]         r_asm;

  logic                w_misalign;
  logic [31:0]         w_wtop;
  logic [1:0]          w_last;
  logic [31:0]         w_full;
  logic                w_addr_hi_unused;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  function automatic logic [31:0] extend(input logic [1:0] sz, input logic sx,
                                         input logic [31:0] d);
    case (sz)
      2'b00:   return {{24{sx & d[7]}}, d[7:0]};
      2'b01:   return {{16{sx & d[15]}}, d[15:0]};
      default: return d;
    endcase
  endfunction

  assign w_misalign = (size == 2'b11) ||
                      (size == 2'b01 && addr[0]) ||
                      (size == 2'b10 && addr[1:0] != 2'b00);

  // Store datum left-justified so byte k is always the top byte after k shifts.
  always_comb begin
    w_wtop = wdata;
    case (size)
      2'b00:   w_wtop = {wdata[7:0], 24'h0};
      2'b01:   w_wtop = {wdata[15:0], 16'h0};
      default: w_wtop = wdata;
    endcase
  end

  always_comb begin
    w_last = 2'd3;
    case (r_size)
      2'b00:   w_last = 2'd0;
      2'b01:   w_last = 2'd1;
      default: w_last = 2'd3;
    endcase
  end

  assign w_full           = {r_asm, mem_rdata};
  assign w_addr_hi_unused = ^addr[31:ADDR_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_size      <= 2'b00;
      r_sext      <= 1'b0;
      r_cnt       <= 2'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_re    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 8'h00;
      r_rdata     <= 32'h0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_size <= size;
            r_sext <= sext;
            r_cnt  <= 2'd0;
            r_busy <= 1'b1;
            if (w_misalign) begin
              r_state <= S_ERR;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end else if (we) begin
              r_state     <= S_WR;
              r_mem_we    <= 1'b1;
              r_mem_addr  <= addr[ADDR_W-1:0];
              r_mem_wdata <= w_wtop[31:24];
            end else begin
              r_state    <= S_RD;
              r_mem_re   <= 1'b1;
              r_mem_addr <= addr[ADDR_W-1:0];
            end
          end
        end
        S_WR: begin
          if (r_cnt == w_last) begin
            r_state     <= S_DONE;
            r_done      <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 8'h00;
          end else begin
            r_cnt       <= r_cnt + 2'd1;
            r_mem_addr  <= r_mem_addr + ADDR_ONE;
            r_mem_wdata <= r_wsh[31:24];
          end
        end
        S_RD: begin
          if (r_cnt == w_last) begin
            r_state    <= S_RD_LAST;
            r_mem_re   <= 1'b0;
            r_mem_addr <= '0;
          end else begin
            r_cnt      <= r_cnt + 2'd1;
            r_mem_addr <= r_mem_addr + ADDR_ONE;
          end
        end
        S_RD_LAST: begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
          r_rdata <= extend(r_size, r_sext, w_full);
        end
        S_DONE, S_ERR: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // RAM data lags its read issue by one cycle, so the first issue has nothing to capture.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE) begin
      r_wsh <= w_wtop << 8;
      r_asm <= 24'h0;
    end else if (r_state == S_WR) begin
      r_wsh <= r_wsh << 8;
    end else if (r_state == S_RD && r_cnt != 2'd0) begin
      r_asm <= w_full[23:0];
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign rdata     = r_rdata;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_we    = r_mem_we;
  assign mem_re    = r_mem_re;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural byte RAM and
// cycle-by-cycle strobe, latency and result checks.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [7:0]  mem_rdata;

  logic [7:0]  ram [256];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .we        (we),
    .size      (size),
    .sext      (sext),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".busy"}, busy, 1'b0);
    chk({tag, ".done"}, done, 1'b0);
    chk({tag, ".err"}, err, 1'b0);
    chk({tag, ".mem_we"}, mem_we, 1'b0);
    chk({tag, ".mem_re"}, mem_re, 1'b0);
    chk({tag, ".mem_addr"}, mem_addr, 8'h00);
  endtask

  task automatic start(input logic w, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] d);
    req = 1'b1; we = w; size = sz; sext = sx; addr = a; wdata = d;
    cyc();
    req = 1'b0;
  endtask

  task automatic store_seq(input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] d, input string tag);
    int n;
    logic [31:0] sh;
    logic [7:0]  ea;
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    start(1'b1, sz, 1'b0, a, d);
    for (int k = 0; k < n; k++) begin
      sh = d >> (8 * (n - 1 - k));
      ea = a[7:0] + 8'(k);
      chk({tag, ".we"}, mem_we, 1'b1);
      chk({tag, ".re"}, mem_re, 1'b0);
      chk({tag, ".addr"}, mem_addr, ea);
      chk({tag, ".wbyte"}, mem_wdata, sh[7:0]);
      chk({tag, ".busy"}, busy, 1'b1);
      chk({tag, ".early_done"}, done, 1'b0);
      cyc();
    end
    chk({tag, ".done"}, done, 1'b1);
    chk({tag, ".err"}, err, 1'b0);
    chk({tag, ".we_off"}, mem_we, 1'b0);
    chk({tag, ".addr_off"}, mem_addr, 8'h00);
    chk({tag, ".wdata_off"}, mem_wdata, 8'h00);
    cyc();
    chk_idle({tag, ".after"});
  endtask

  task automatic load_seq(input logic [1:0] sz, input logic sx, input logic [31:0] a,
                          input logic [31:0] expv, input string tag);
    int n;
    logic [7:0] ea;
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    start(1'b0, sz, sx, a, 32'h0);
    for (int k = 0; k < n; k++) begin
      ea = a[7:0] + 8'(k);
      chk({tag, ".re"}, mem_re, 1'b1);
      chk({tag, ".we"}, mem_we, 1'b0);
      chk({tag, ".addr"}, mem_addr, ea);
      chk({tag, ".early_done"}, done, 1'b0);
      cyc();
    end
    chk({tag, ".re_off"}, mem_re, 1'b0);
    chk({tag, ".addr_off"}, mem_addr, 8'h00);
    chk({tag, ".last_busy"}, busy, 1'b1);
    chk({tag, ".last_done"}, done, 1'b0);
    cyc();
    chk({tag, ".done"}, done, 1'b1);
    chk({tag, ".err"}, err, 1'b0);
    chk({tag, ".rdata"}, rdata, expv);
    cyc();
    chk_idle({tag, ".after"});
    chk({tag, ".rdata_hold"}, rdata, expv);
  endtask

  task automatic err_seq(input logic w, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] prev, input string tag);
    start(w, sz, 1'b1, a, 32'hDEADBEEF);
    chk({tag, ".done"}, done, 1'b1);
    chk({tag, ".err"}, err, 1'b1);
    chk({tag, ".busy"}, busy, 1'b1);
    chk({tag, ".we"}, mem_we, 1'b0);
    chk({tag, ".re"}, mem_re, 1'b0);
    chk({tag, ".rdata"}, rdata, prev);
    cyc();
    chk_idle({tag, ".after"});
    chk({tag, ".rdata_hold"}, rdata, prev);
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; sext = 1'b0;
    addr = 32'h0; wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk_idle("rst");
    chk("rst.rdata", rdata, 32'h0);
    chk("rst.wdata", mem_wdata, 8'h00);
    reset = 1'b0;
    cyc();
    chk_idle("post_rst");

    store_seq(2'b10, 32'h10, 32'h12345678, "sw10");
    load_seq(2'b10, 1'b0, 32'h10, 32'h12345678, "lw10");
    load_seq(2'b10, 1'b1, 32'hFFFF_FF10, 32'h12345678, "lw10_hi");

    store_seq(2'b00, 32'h20, 32'h00000080, "sb20");
    load_seq(2'b00, 1'b1, 32'h20, 32'hFFFFFF80, "lb20");
    load_seq(2'b00, 1'b0, 32'h20, 32'h00000080, "lbu20");

    store_seq(2'b01, 32'h40, 32'hCAFEBEEF, "sh40");
    chk("sh40.ram40", ram[8'h40], 8'hBE);
    chk("sh40.ram41", ram[8'h41], 8'hEF);
    load_seq(2'b01, 1'b1, 32'h40, 32'hFFFFBEEF, "lh40");
    load_seq(2'b01, 1'b0, 32'h40, 32'h0000BEEF, "lhu40");
    load_seq(2'b00, 1'b1, 32'h41, 32'hFFFFFFEF, "lb41");

    err_seq(1'b0, 2'b10, 32'h41, 32'hFFFFFFEF, "lw41");
    err_seq(1'b1, 2'b01, 32'h03, 32'hFFFFFFEF, "sh03");
    err_seq(1'b0, 2'b11, 32'h00, 32'hFFFFFFEF, "sz11");

    // req held high across two stores: the second is taken only from IDLE
    req = 1'b1; we = 1'b1; size = 2'b00; sext = 1'b0; addr = 32'h60; wdata = 32'hA5;
    cyc();
    chk("b2b.first_we", mem_we, 1'b1);
    chk("b2b.first_addr", mem_addr, 8'h60);
    chk("b2b.first_data", mem_wdata, 8'hA5);
    addr = 32'h61; wdata = 32'h5A;
    cyc();
    chk("b2b.first_done", done, 1'b1);
    chk("b2b.no_we", mem_we, 1'b0);
    cyc();
    chk("b2b.gap_busy", busy, 1'b0);
    chk("b2b.gap_we", mem_we, 1'b0);
    chk("b2b.gap_done", done, 1'b0);
    cyc();
    req = 1'b0;
    chk("b2b.second_we", mem_we, 1'b1);
    chk("b2b.second_addr", mem_addr, 8'h61);
    chk("b2b.second_data", mem_wdata, 8'h5A);
    cyc();
    chk("b2b.second_done", done, 1'b1);
    cyc();
    chk_idle("b2b.after");
    chk("b2b.ram60", ram[8'h60], 8'hA5);
    chk("b2b.ram61", ram[8'h61], 8'h5A);

    // reset lands while the third byte of a word store is on the bus
    store_seq(2'b10, 32'h50, 32'hAAAAAAAA, "sw50_pre");
    start(1'b1, 2'b10, 1'b0, 32'h50, 32'h11223344);
    chk("abort.addr0", mem_addr, 8'h50);
    cyc();
    chk("abort.addr1", mem_addr, 8'h51);
    cyc();
    chk("abort.addr2", mem_addr, 8'h52);
    chk("abort.we2", mem_we, 1'b1);
    reset = 1'b1;
    #1;
    chk_idle("abort.async");
    chk("abort.rdata", rdata, 32'h0);
    chk("abort.wdata", mem_wdata, 8'h00);
    cyc();
    chk("abort.no_done", done, 1'b0);
    cyc();
    reset = 1'b0;
    cyc();
    chk_idle("abort.idle");
    chk("abort.ram50", ram[8'h50], 8'h11);
    chk("abort.ram51", ram[8'h51], 8'h22);
    chk("abort.ram52", ram[8'h52], 8'hAA);
    chk("abort.ram53", ram[8'h53], 8'hAA);
    load_seq(2'b10, 1'b0, 32'h50, 32'h1122AAAA, "lw50");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
